// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the hazard controller
// Purpose: memory-wait FSM state encodings and the zero-register index
//          that is also used by the forwarding unit.
// Ports:   none (package)
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } hc_state_t;

    // x0 is hardwired to zero, so it can never carry a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter with sync clear
// Purpose: counts cycles with inc=1, sticks at all-ones, clr wins over inc.
// Ports:   clk, rst_n (async active-low), inc, clr -> cnt[W-1:0]
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use bubble, jump flush and memory-stall control
// Purpose: combinational bubble/flush flags and PC/IF-ID enables for the
//          decode stage, a memory-wait FSM that freezes the pipeline while
//          data memory is busy (with sticky timeout fault), and saturating
//          performance counters.
// Ports:   clk, rst_n (async active-low)
//          ID:    Rs1_id, Rs2_id, rs1_used_id, rs2_used_id
//          EX:    Rd_id_ex, MemRead_id_ex, jump_ex
//          MEM:   mem_busy;   perf: cnt_clr
//          out:   load_use_flag, jump_flag, pc_write_en, if_id_write_en,
//                 pipe_hold, mem_err, lu_cnt, flush_cnt, wait_cnt
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1_id,
    input  logic [4:0]       Rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       Rd_id_ex,
    input  logic             MemRead_id_ex,
    input  logic             jump_ex,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             load_use_flag,
    output logic             jump_flag,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    hc_state_t        state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mem_err_q, mem_err_d;
    logic             lu_raw;
    logic             wait_inc;

    assign lu_raw = MemRead_id_ex && (Rd_id_ex != REG_ZERO) &&
                    ((rs1_used_id && (Rs1_id == Rd_id_ex)) ||
                     (rs2_used_id && (Rs2_id == Rd_id_ex)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    // tmo_q counts consecutive busy cycles including the RUN entry cycle,
    // so the FSM sits in WAIT for exactly MEM_TIMEOUT busy cycles.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_err_d = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_WAIT;
                    tmo_d   = TMO_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    state_d = ST_RUN;
                end else if (tmo_q == TMO_MAX) begin
                    state_d   = ST_FAULT;
                    mem_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Defaults are the frozen pattern, shared by reset, busy and FAULT.
    // A non-busy WAIT cycle is the release cycle and behaves exactly as RUN.
    always_comb begin
        load_use_flag  = 1'b0;
        jump_flag      = 1'b0;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        pipe_hold      = 1'b1;
        if (rst_n && (state_q != ST_FAULT) && !mem_busy) begin
            pipe_hold = 1'b0;
            if (jump_ex) begin
                // the ID instruction is squashed, so its load-use is moot
                jump_flag      = 1'b1;
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
            end else if (lu_raw) begin
                load_use_flag = 1'b1;
            end else begin
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
            end
        end
    end

    assign mem_err  = mem_err_q;
    assign wait_inc = mem_busy && (state_q != ST_FAULT);

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_use_flag),
        .clr   (cnt_clr),
        .cnt   (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (jump_flag),
        .clr   (cnt_clr),
        .cnt   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .clr   (cnt_clr),
        .cnt   (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1_id, Rs2_id, Rd_id_ex;
    logic       rs1_used_id, rs2_used_id, MemRead_id_ex, jump_ex, mem_busy, cnt_clr;
    logic       load_use_flag, jump_flag, pc_write_en, if_id_write_en, pipe_hold, mem_err;
    logic [1:0] lu_cnt, flush_cnt, wait_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       j;
        logic       busy;
        logic       clr;
    } stim_t;

    logic [11:0] sb[$];

    hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Rs1_id         (Rs1_id),
        .Rs2_id         (Rs2_id),
        .rs1_used_id    (rs1_used_id),
        .rs2_used_id    (rs2_used_id),
        .Rd_id_ex       (Rd_id_ex),
        .MemRead_id_ex  (MemRead_id_ex),
        .jump_ex        (jump_ex),
        .mem_busy       (mem_busy),
        .cnt_clr        (cnt_clr),
        .load_use_flag  (load_use_flag),
        .jump_flag      (jump_flag),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .pipe_hold      (pipe_hold),
        .mem_err        (mem_err),
        .lu_cnt         (lu_cnt),
        .flush_cnt      (flush_cnt),
        .wait_cnt       (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t S(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic j, input logic busy,
                                input logic clr);
        S = {rs1, rs2, u1, u2, rd, mr, j, busy, clr};
    endfunction

    // expected {lu, jf, pcw, ifw, hold, err, lu_cnt, flush_cnt, wait_cnt}
    function automatic logic [11:0] E(input logic lu, input logic jf, input logic pcw,
                                      input logic ifw, input logic hold, input logic err,
                                      input logic [1:0] luc, input logic [1:0] flc,
                                      input logic [1:0] wc);
        E = {lu, jf, pcw, ifw, hold, err, luc, flc, wc};
    endfunction

    function automatic logic [11:0] obs();
        obs = {load_use_flag, jump_flag, pc_write_en, if_id_write_en, pipe_hold,
               mem_err, lu_cnt, flush_cnt, wait_cnt};
    endfunction

    function automatic stim_t IDLE();
        IDLE = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic drive(input stim_t s);
        Rs1_id        = s.rs1;
        Rs2_id        = s.rs2;
        rs1_used_id   = s.u1;
        rs2_used_id   = s.u2;
        Rd_id_ex      = s.rd;
        MemRead_id_ex = s.mr;
        jump_ex       = s.j;
        mem_busy      = s.busy;
        cnt_clr       = s.clr;
    endtask

    // Drive a stimulus, queue its expectation, then wait to the sampling edge.
    task automatic apply(input stim_t s, input logic [11:0] exp_v);
        drive(s);
        sb.push_back(exp_v);
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got, ev;
        rst_n = 1'b0;
        drive(S(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        sb.push_back(E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
        #13;
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL reset_values got=%03h exp=%03h", got, ev);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        apply(IDLE(), E(0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0));
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL reset_release_idle got=%03h exp=%03h", got, ev);
        end
        advance();
    endtask

    task automatic test_load_use();
        stim_t       st[6];
        logic [11:0] ex[6];
        logic [11:0] got, ev;
        st[0] = S(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); ex[0] = E(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
        st[1] = S(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); ex[1] = E(0, 0, 1, 1, 0, 0, 2'd1, 2'd0, 2'd0);
        st[2] = S(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); ex[2] = E(0, 0, 1, 1, 0, 0, 2'd1, 2'd0, 2'd0);
        st[3] = S(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); ex[3] = E(1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0);
        st[4] = S(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); ex[4] = E(0, 0, 1, 1, 0, 0, 2'd2, 2'd0, 2'd0);
        st[5] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); ex[5] = E(0, 0, 1, 1, 0, 0, 2'd2, 2'd0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            apply(st[i], ex[i]);
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL load_use step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_jump_priority();
        stim_t       st[3];
        logic [11:0] ex[3];
        logic [11:0] got, ev;
        st[0] = S(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); ex[0] = E(0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0);
        st[1] = IDLE();                                                  ex[1] = E(0, 0, 1, 1, 0, 0, 2'd0, 2'd1, 2'd0);
        st[2] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); ex[2] = E(0, 0, 1, 1, 0, 0, 2'd0, 2'd1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            apply(st[i], ex[i]);
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL jump_priority step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_mem_stall();
        stim_t       st[6];
        logic [11:0] ex[6];
        logic [11:0] got, ev;
        st[0] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); ex[0] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0);
        st[1] = st[0];                                                   ex[1] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1);
        st[2] = st[0];                                                   ex[2] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        st[3] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); ex[3] = E(0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd3);
        st[4] = IDLE();                                                  ex[4] = E(0, 0, 1, 1, 0, 0, 2'd0, 2'd1, 2'd3);
        st[5] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); ex[5] = E(0, 0, 1, 1, 0, 0, 2'd0, 2'd1, 2'd3);
        for (int i = 0; i < 6; i++) begin
            apply(st[i], ex[i]);
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL mem_stall step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_lu_through_stall();
        stim_t       st[3];
        logic [11:0] ex[3];
        logic [11:0] got, ev;
        st[0] = S(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0); ex[0] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0);
        st[1] = S(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); ex[1] = E(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1);
        st[2] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); ex[2] = E(0, 0, 1, 1, 0, 0, 2'd1, 2'd0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            apply(st[i], ex[i]);
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL lu_through_stall step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        stim_t       st[8];
        logic [11:0] ex[8];
        logic [11:0] got, ev;
        stim_t       busy_s;
        busy_s = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        st[0] = busy_s; ex[0] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0);
        st[1] = busy_s; ex[1] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1);
        st[2] = busy_s; ex[2] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2);
        st[3] = busy_s; ex[3] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3);
        st[4] = busy_s; ex[4] = E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3);
        st[5] = busy_s; ex[5] = E(0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd3);
        st[6] = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); ex[6] = E(0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd3);
        st[7] = IDLE();                                                  ex[7] = E(0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            apply(st[i], ex[i]);
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL timeout step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
        rst_n = 1'b0;
        sb.push_back(E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
        #2;
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL timeout_reset got=%03h exp=%03h", got, ev);
        end
        rst_n = 1'b1;
        apply(IDLE(), E(0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0));
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL timeout_after_reset got=%03h exp=%03h", got, ev);
        end
        advance();
    endtask

    task automatic test_saturation();
        stim_t       hit;
        logic [11:0] got, ev;
        logic [1:0]  c;
        hit = S(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            c = (i > 3) ? 2'd3 : 2'(i);
            if (i == 5) begin
                hit.clr = 1'b1;
            end
            if (i == 6) begin
                apply(IDLE(), E(0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0));
            end else begin
                apply(hit, E(1, 0, 0, 0, 0, 0, c, 2'd0, 2'd0));
            end
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL saturation step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_async_reset_mid_wait();
        logic [11:0] got, ev;
        stim_t       busy_s;
        busy_s = S(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(busy_s, E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'(i)));
            got = obs(); ev = sb.pop_front(); total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL async_reset_wait step%0d got=%03h exp=%03h", i, got, ev);
            end
            advance();
        end
        rst_n = 1'b0;
        sb.push_back(E(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
        #2;
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL async_reset_immediate got=%03h exp=%03h", got, ev);
        end
        drive(IDLE());
        #1 rst_n = 1'b1;
        apply(IDLE(), E(0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0));
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL async_reset_release got=%03h exp=%03h", got, ev);
        end
        advance();
        apply(IDLE(), E(0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0));
        got = obs(); ev = sb.pop_front(); total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL async_reset_run got=%03h exp=%03h", got, ev);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jump_priority();
        test_mem_stall();
        test_lu_through_stall();
        test_timeout();
        test_saturation();
        test_async_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
